sr_latch_driver: RTL and testbench



---
 rtl/sr_drv_pkg.sv | 20 ++
 rtl/sr_latch_driver_if.sv | 26 ++
 rtl/sr_latch_driver_sync2.sv | 23 ++
 rtl/sr_latch_driver.sv | 117 +++++++++++
 tb/tb_sr_latch_driver.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the gated SR latch driver.
// The readback option is selected by the SR_DRV_READBACK_EN macro in sr_latch_driver.
package sr_drv_pkg;

   localparam int CNT_W                 = 4;
   localparam int DEFAULT_PULSE_CYCLES  = 2;
   localparam int DEFAULT_SETTLE_CYCLES = 3;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      SETTLE,
      CHECK
   } drvState_t;

   typedef logic [CNT_W-1:0] cycleCount_t;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/status and latch-side signals of the SR latch driver.
// master = clocked control logic plus the latch; slave = the driver.
interface sr_latch_driver_if;

   logic Req;
   logic Level;
   logic Busy;
   logic Done;
   logic Err;
   logic S;
   logic R;
   logic En;
   logic Q_fb;
   logic notQ_fb;

   modport master (
      output Req, Level, Q_fb, notQ_fb,
      input  Busy, Done, Err, S, R, En
   );

   modport slave (
      input  Req, Level, Q_fb, notQ_fb,
      output Busy, Done, Err, S, R, En
   );

endinterface

// File: rtl/sr_latch_driver_sync2.sv
// Generic two-flop synchronizer, asynchronously reset to 0.
// Used by sr_latch_driver to bring latch feedback into the clock domain.
module sync2 (
   input  logic Clk,
   input  logic Rst,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to resolve.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences a one-cycle set/reset request into a setup/pulse/hold/settle S/R/En waveform.
// Define SR_DRV_READBACK_EN to add feedback synchronizers, the CHECK state and Err.
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int PULSE_CYCLES  = DEFAULT_PULSE_CYCLES,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
   input  logic                Clk,
   input  logic                Rst,
   sr_latch_driver_if.slave    bus
);

   localparam cycleCount_t PULSE_LOAD  = cycleCount_t'(PULSE_CYCLES - 1);
   localparam cycleCount_t SETTLE_LOAD = cycleCount_t'(SETTLE_CYCLES - 1);

   drvState_t   state, stateNext;
   cycleCount_t cnt, cntNext;
   logic        levelReg, levelNext;
   logic        sNext, rNext, enNext, busyNext, doneNext, errNext;
   logic        checkFail;

`ifdef SR_DRV_READBACK_EN
   logic qSync, notQSync;

   sync2 qSyncInst    (.Clk(Clk), .Rst(Rst), .d(bus.Q_fb),    .q(qSync));
   sync2 notQSyncInst (.Clk(Clk), .Rst(Rst), .d(bus.notQ_fb), .q(notQSync));

   // A write failed if Q disagrees with the request or the latch shows an illegal Q==notQ.
   assign checkFail = (qSync != levelReg) || (qSync == notQSync);
`else
   assign checkFail = 1'b0;
`endif

   // State register plus registered outputs, so S/R/En never glitch.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         cnt      <= '0;
         levelReg <= 1'b0;
         bus.S    <= 1'b0;
         bus.R    <= 1'b0;
         bus.En   <= 1'b0;
         bus.Busy <= 1'b0;
         bus.Done <= 1'b0;
         bus.Err  <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         levelReg <= levelNext;
         bus.S    <= sNext;
         bus.R    <= rNext;
         bus.En   <= enNext;
         bus.Busy <= busyNext;
         bus.Done <= doneNext;
         bus.Err  <= errNext;
      end
   end

   // Next state, then outputs decoded from the state being entered.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      levelNext = levelReg;
      doneNext  = 1'b0;
      errNext   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.Req) begin
               stateNext = SETUP;
               levelNext = bus.Level;
            end
         end
         SETUP: begin
            stateNext = PULSE;
            cntNext   = PULSE_LOAD;
         end
         PULSE: begin
            if (cnt == '0) stateNext = HOLD;
            else           cntNext   = cnt - 1'b1;
         end
         HOLD: begin
            stateNext = SETTLE;
            cntNext   = SETTLE_LOAD;
         end
         SETTLE: begin
            if (cnt == '0) begin
`ifdef SR_DRV_READBACK_EN
               stateNext = CHECK;
`else
               stateNext = IDLE;
               doneNext  = 1'b1;
`endif
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         CHECK: begin
            stateNext = IDLE;
            doneNext  = 1'b1;
            errNext   = checkFail;
         end
         default: stateNext = IDLE;
      endcase

      sNext    = 1'b0;
      rNext    = 1'b0;
      enNext   = (stateNext == PULSE);
      busyNext = (stateNext != IDLE);
      if (stateNext == SETUP || stateNext == PULSE || stateNext == HOLD) begin
         sNext = levelNext;
         rNext = ~levelNext;
      end
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver against a behavioural gated SR latch.
// Honours SR_DRV_READBACK_EN so it matches whichever build is compiled.
module tb_sr_latch_driver;
   import sr_drv_pkg::*;

   localparam int PC = DEFAULT_PULSE_CYCLES;
   localparam int SC = DEFAULT_SETTLE_CYCLES;
`ifdef SR_DRV_READBACK_EN
   localparam int LAT = PC + SC + 3;
   localparam bit READBACK = 1'b1;
`else
   localparam int LAT = PC + SC + 2;
   localparam bit READBACK = 1'b0;
`endif

   logic Clk;
   logic Rst;
   int   errors;
   int   checks;
   int   forceMode;
   logic latchQ;
   logic prevS, prevR, prevEn;

   sr_latch_driver_if bus ();

   sr_latch_driver #(.PULSE_CYCLES(PC), .SETTLE_CYCLES(SC)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural gated SR latch; forceMode 1 pins Q_fb low, 2 makes Q_fb=notQ_fb=1.
   always @(bus.S or bus.R or bus.En) begin
      if (bus.En) begin
         if (bus.S && !bus.R)      latchQ = 1'b1;
         else if (bus.R && !bus.S) latchQ = 1'b0;
      end
   end
   assign bus.Q_fb    = (forceMode == 1) ? 1'b0 : (forceMode == 2) ? 1'b1 : latchQ;
   assign bus.notQ_fb = (forceMode == 2) ? 1'b1 : ~latchQ;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Latch-safety invariants watched on every cycle.
   always @(negedge Clk) begin
      checkOutput("srExclusive", {7'd0, bus.S & bus.R}, 8'd0);
      if (prevEn && bus.En)
         checkOutput("srStableWhileEn", {6'd0, bus.S, bus.R}, {6'd0, prevS, prevR});
      if (!prevEn && bus.En) begin
         checkOutput("srSetupBeforeEn", {6'd0, bus.S, bus.R}, {6'd0, prevS, prevR});
         checkOutput("srValidAtEnRise", {7'd0, bus.S ^ bus.R}, 8'd1);
      end
      prevS  = bus.S;
      prevR  = bus.R;
      prevEn = bus.En;
   end

   // One write; expected waveform is derived from the cycle offsets after the sampling edge.
   task automatic applyStimulus(input logic lvl, input int fm, input bit spam,
                                input bit preDriven, input bit chain, input logic nextLvl);
      logic qF, nqF, errE;
      logic [5:0] expW, obsW;
      forceMode = fm;
      if (!preDriven) begin
         @(negedge Clk);
         bus.Req   = 1'b1;
         bus.Level = lvl;
      end
      qF   = (fm == 1) ? 1'b0 : (fm == 2) ? 1'b1 : lvl;
      nqF  = (fm == 2) ? 1'b1 : ~lvl;
      errE = READBACK && ((qF != lvl) || (qF == nqF));
      for (int j = 0; j <= LAT; j++) begin
         @(posedge Clk);
         @(negedge Clk);
         expW[5] = lvl && (j <= PC + 1);
         expW[4] = !lvl && (j <= PC + 1);
         expW[3] = (j >= 1) && (j <= PC);
         expW[2] = (j < LAT);
         expW[1] = (j == LAT);
         expW[0] = (j == LAT) && errE;
         obsW = {bus.S, bus.R, bus.En, bus.Busy, bus.Done, bus.Err};
         checkOutput($sformatf("wave lvl=%0b fm=%0d j=%0d", lvl, fm, j), {2'b00, obsW}, {2'b00, expW});
         if (j < LAT) begin
            bus.Req   = spam ? 1'($urandom) : 1'b0;
            bus.Level = spam ? 1'($urandom) : bus.Level;
         end else if (chain) begin
            bus.Req   = 1'b1;
            bus.Level = nextLvl;
         end else begin
            bus.Req = 1'b0;
         end
      end
      checkOutput($sformatf("latchQ lvl=%0b", lvl), {7'd0, latchQ}, {7'd0, lvl});
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      forceMode = 0;
      latchQ    = 1'b0;
      prevS     = 1'b0;
      prevR     = 1'b0;
      prevEn    = 1'b0;
      bus.Req   = 1'b0;
      bus.Level = 1'b0;
      Rst       = 1'b0;
      #1 Rst    = 1'b1;
      #2;
      checkOutput("resetOutputs", {2'b00, bus.S, bus.R, bus.En, bus.Busy, bus.Done, bus.Err}, 8'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      checkOutput("resetHeld", {2'b00, bus.S, bus.R, bus.En, bus.Busy, bus.Done, bus.Err}, 8'd0);

      // Set, then reset with Req spammed while busy and chained in the Done cycle.
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Bad feedback: Q stuck low, then Q==notQ.
      applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset while En is high.
      @(negedge Clk);
      bus.Req   = 1'b1;
      bus.Level = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      bus.Req = 1'b0;
      @(posedge Clk);
      #2;
      checkOutput("midPulseEn", {7'd0, bus.En}, 8'd1);
      Rst = 1'b1;
      #1;
      checkOutput("asyncResetDrop", {2'b00, bus.S, bus.R, bus.En, bus.Busy, bus.Done, bus.Err}, 8'd0);
      @(negedge Clk);
      Rst = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge Clk);
         checkOutput($sformatf("noDoneAfterReset %0d", i), {6'd0, bus.Done, bus.Busy}, 8'd0);
      end
      checkOutput("latchKeptAfterReset", {7'd0, latchQ}, 8'd1);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized writes, feedback faults and busy-time noise.
      for (int n = 0; n < 10; n++)
         applyStimulus(1'($urandom), int'($urandom_range(0, 2)), 1'($urandom),
                       1'b0, 1'b0, 1'b0);

      forceMode = 0;
      repeat (2) @(negedge Clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
